// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_sequencer
//  Description : Multi-cycle shift-and-add multiplier controller. It borrows
//                the shared execute-stage Alu and returns the low BITS bits of
//                ReqA*ReqB, with an unsigned-overflow flag and a zero flag.
//                Index 0 of every vector is the MSB.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [0:BITS-1] ReqA,
    input  logic [0:BITS-1] ReqB,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [0:BITS-1] RspResult,
    output logic            RspOverflow,
    output logic            RspZero,
    output logic            AluOwn,
    output logic [0:BITS-1] AluSrcA,
    output logic [0:BITS-1] AluSrcB,
    output logic [0:1]      AluControl,
    input  logic [0:BITS-1] AluResult,
    input  logic [0:3]      AluFlags
);

    localparam int                CNT_W      = $clog2(BITS) + 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(BITS - 1);
    localparam logic [0:1]        C_ALU_ADD  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [0:BITS-1]  r_p;
    logic [0:BITS-1]  r_m;
    logic [0:BITS-1]  r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lost;
    logic             r_ovf;

    logic             w_accept;
    logic [0:BITS-1]  w_q_shr;
    logic             w_calc_last;
    logic             w_add_now;
    logic             w_unused_flags;

    assign w_accept       = ReqValid && ReqReady;
    assign w_q_shr        = r_q >> 1;
    // Stop as soon as no multiplier bits remain, or after the last bit position.
    assign w_calc_last    = (w_q_shr == '0) || (r_cnt == C_CNT_LAST);
    // Bit BITS-1 is the LSB of the multiplier: add M into P when it is set.
    assign w_add_now      = r_q[BITS-1];
    // Only the carry flag matters; the remaining Alu flags are intentionally ignored.
    assign w_unused_flags = ^{AluFlags[0], AluFlags[2], AluFlags[3]};

    // Result outputs are a direct view of the accumulator and sticky overflow.
    assign RspResult   = r_p;
    assign RspOverflow = r_ovf;
    assign RspZero     = (r_p == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake / Alu-borrow outputs.
    always_comb begin
        w_state_nxt = r_state;
        ReqReady    = 1'b0;
        RspValid    = 1'b0;
        AluOwn      = 1'b0;
        AluSrcA     = '0;
        AluSrcB     = '0;
        AluControl  = C_ALU_ADD;
        case (r_state)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    w_state_nxt = (ReqB == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                AluOwn  = 1'b1;
                AluSrcA = r_p;
                AluSrcB = r_m;
                if (w_calc_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, one shift-and-add step per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_m    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_lost <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_p    <= '0;
                r_m    <= ReqA;
                r_q    <= ReqB;
                r_cnt  <= '0;
                r_lost <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            if (w_add_now) begin
                // A carry out of the add, or a multiplicand bit already shifted
                // off the top, both mean the true product needs more than BITS bits.
                r_p   <= AluResult;
                r_ovf <= r_ovf | AluFlags[1] | r_lost;
            end
            r_m    <= r_m << 1;
            r_lost <= r_lost | r_m[0];
            r_q    <= w_q_shr;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_sequencer
//  Description : Self-checking bench for alu_mul_sequencer with a behavioural
//                Alu adder model, directed vector table and reset/backpressure
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;

    localparam int BITS = 64;

    logic            clk;
    logic            rst_n;
    logic            ReqValid;
    logic            ReqReady;
    logic [0:BITS-1] ReqA;
    logic [0:BITS-1] ReqB;
    logic            RspValid;
    logic            RspReady;
    logic [0:BITS-1] RspResult;
    logic            RspOverflow;
    logic            RspZero;
    logic            AluOwn;
    logic [0:BITS-1] AluSrcA;
    logic [0:BITS-1] AluSrcB;
    logic [0:1]      AluControl;
    logic [0:BITS-1] AluResult;
    logic [0:3]      AluFlags;

    logic            w_carry;
    logic [0:BITS-1] w_sum;

    int n_checks;
    int n_pass;

    alu_mul_sequencer #(.BITS(BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqA        (ReqA),
        .ReqB        (ReqB),
        .RspValid    (RspValid),
        .RspReady    (RspReady),
        .RspResult   (RspResult),
        .RspOverflow (RspOverflow),
        .RspZero     (RspZero),
        .AluOwn      (AluOwn),
        .AluSrcA     (AluSrcA),
        .AluSrcB     (AluSrcB),
        .AluControl  (AluControl),
        .AluResult   (AluResult),
        .AluFlags    (AluFlags)
    );

    // Alu model: add only, carry reported on flag bit 1.
    assign {w_carry, w_sum} = {1'b0, AluSrcA} + {1'b0, AluSrcB};
    assign AluResult = w_sum;
    assign AluFlags  = {w_sum[0], w_carry, 1'b0, (w_sum == '0)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        ovf;
        logic        zero;
        int          cycles;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one request, count CALC cycles, check the response, then consume it.
    task automatic run_txn(input vec_t v);
        int cyc;
        int own;
        logic ctl_bad;
        cyc     = 0;
        own     = 0;
        ctl_bad = 1'b0;
        check({v.name, " ReqReady idle"}, 64'(ReqReady), 64'd1);
        ReqA     = v.a;
        ReqB     = v.b;
        ReqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        ReqA     = ~v.a;
        ReqB     = ~v.b;
        while (!RspValid && cyc < 200) begin
            if (AluOwn) begin
                own++;
                if (AluControl !== 2'b00) ctl_bad = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check({v.name, " RspValid"}, 64'(RspValid), 64'd1);
        check({v.name, " latency"}, 64'(cyc), 64'(v.cycles));
        check({v.name, " AluOwn cycles"}, 64'(own), 64'(v.cycles));
        check({v.name, " AluControl add"}, 64'(ctl_bad), 64'd0);
        check({v.name, " RspResult"}, RspResult, v.res);
        check({v.name, " RspOverflow"}, 64'(RspOverflow), 64'(v.ovf));
        check({v.name, " RspZero"}, 64'(RspZero), 64'(v.zero));
        check({v.name, " AluOwn in DONE"}, 64'(AluOwn), 64'd0);
        RspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RspReady = 1'b0;
        check({v.name, " RspValid cleared"}, 64'(RspValid), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] held_res;
        logic        held_ovf;
        logic        bp_bad;
        int          wait_cyc;
        vec_t        v;

        n_checks = 0;
        n_pass   = 0;

        vecs.push_back('{"3x5",       64'd3,  64'd5,  64'd15, 1'b0, 1'b0, 3});
        vecs.push_back('{"123x0",     64'd123, 64'd0, 64'd0,  1'b0, 1'b1, 0});
        vecs.push_back('{"ones x2",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                         64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 2});
        vecs.push_back('{"msb x3",    64'h8000_0000_0000_0000, 64'd3,
                         64'h8000_0000_0000_0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"7 x msb",   64'd7, 64'h8000_0000_0000_0000,
                         64'h8000_0000_0000_0000, 1'b1, 1'b0, 64});
        vecs.push_back('{"1x1",       64'd1,  64'd1,  64'd1,  1'b0, 1'b0, 1});
        vecs.push_back('{"0x5",       64'd0,  64'd5,  64'd0,  1'b0, 1'b1, 3});
        vecs.push_back('{"ones sq",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'd1, 1'b1, 1'b0, 64});
        vecs.push_back('{"2^32 sq",   64'h1_0000_0000, 64'h1_0000_0000,
                         64'd0, 1'b1, 1'b1, 33});
        vecs.push_back('{"1234x5678", 64'd1234, 64'd5678, 64'd7006652, 1'b0, 1'b0, 13});

        rst_n    = 1'b0;
        ReqValid = 1'b0;
        ReqA     = '0;
        ReqB     = '0;
        RspReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("reset ReqReady", 64'(ReqReady), 64'd1);
        check("reset RspValid", 64'(RspValid), 64'd0);
        check("reset AluOwn", 64'(AluOwn), 64'd0);
        check("reset AluSrcA", AluSrcA, 64'd0);
        check("reset AluSrcB", AluSrcB, 64'd0);
        check("reset RspResult", RspResult, 64'd0);
        check("reset RspZero", 64'(RspZero), 64'd1);

        foreach (vecs[i]) begin
            run_txn(vecs[i]);
        end

        // Backpressure: response must hold while RspReady is low.
        ReqA     = 64'd3;
        ReqB     = 64'd5;
        ReqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        wait_cyc = 0;
        while (!RspValid && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("bp RspValid", 64'(RspValid), 64'd1);
        held_res = RspResult;
        held_ovf = RspOverflow;
        bp_bad   = 1'b0;
        ReqValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (RspValid !== 1'b1 || RspResult !== held_res ||
                RspOverflow !== held_ovf || ReqReady !== 1'b0) bp_bad = 1'b1;
        end
        ReqValid = 1'b0;
        check("bp hold stable", 64'(bp_bad), 64'd0);
        check("bp result", held_res, 64'd15);
        RspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RspReady = 1'b0;
        check("bp released", 64'(RspValid), 64'd0);

        // Abort a long multiply with a one-cycle reset in the middle of CALC.
        ReqA     = 64'd7;
        ReqB     = 64'h8000_0000_0000_0000;
        ReqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort mid CALC", 64'(AluOwn), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort ReqReady", 64'(ReqReady), 64'd1);
        check("abort RspValid", 64'(RspValid), 64'd0);
        check("abort AluOwn", 64'(AluOwn), 64'd0);
        check("abort RspResult", RspResult, 64'd0);
        bp_bad = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (RspValid !== 1'b0 || AluOwn !== 1'b0) bp_bad = 1'b1;
        end
        check("abort no response", 64'(bp_bad), 64'd0);

        v = '{"6x7", 64'd6, 64'd7, 64'd42, 1'b0, 1'b0, 3};
        run_txn(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
